inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch front end of the OpenMIPS pipeline, sitting directly upstream of the instruction ROM and replacing the bare PC register plus IF/ID latch. Each cycle it drives the PC and chip enable to the combinational ROM and captures the returned word with its PC into a small fetch buffer. It presents the buffered {pc, inst} pairs to decode under a valid/ready handshake. It also applies pipeline stalls, branch redirects (held pending across stalls) and exception flush redirects.

## Interface
Parameters: none (widths come from `defines.v`).
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- stall_pc  in  1  from ctrl; freezes PC and fetch
- flush  in  1  exception flush; redirect to new_pc
- new_pc  in  InstAddrBus  exception handler address
- branch_flag_i  in  1  one-cycle branch redirect pulse from decode
- branch_target_address_i  in  InstAddrBus  branch target
- pc  out  InstAddrBus  fetch address to ROM
- ce  out  1  ROM chip enable
- inst_i  in  InstBus  ROM data; same-cycle response to pc
- id_valid  out  1  buffer head valid
- id_ready  in  1  decode accepts head this cycle
- id_pc  out  InstAddrBus  head PC
- id_inst  out  InstBus  head instruction

## Operation
- Reset values: pc=0, ce=0, id_valid=0, id_pc=ZeroWord, id_inst=ZeroWord, buffer empty, pending branch cleared.
- ce rises on the first edge with rst=0 and stays 1 until the next reset.
- Fetch fires when ce=1, stall_pc=0, no flush, no branch or pending branch being applied, and the buffer has room. Room is defined under Configuration.
- On a fire, {pc, inst_i} is pushed into the buffer and pc becomes pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- A pop occurs when id_valid && id_ready. The head advances, and a push and a pop in the same cycle are both honoured.
- Redirect priority is flush > branch > stall > sequential.
  - flush: clear the buffer, clear any pending branch, set pc=new_pc. This is applied even when stall_pc=1.
  - branch_flag_i with stall_pc=0: clear the buffer, set pc=target, suppress this cycle's push.
  - branch_flag_i with stall_pc=1: latch the target into the pending register. It is applied on the first cycle with stall_pc=0, with the same effect as a branch.
  - A new branch_flag_i while a branch is pending overwrites the pending target.
- Delay-slot contract: decode asserts branch_flag_i only after it has accepted the delay-slot instruction. The fetch unit therefore discards every buffered entry on a redirect.
- Redirect targets are forced word-aligned: bits [1:0] are cleared.
- Stall: pc and the buffer contents are held, but pops still occur, so decode drains the buffer.

## Timing
- Reset released before edge E0: ce=1 and pc=0 after E0.
- The first instruction has id_valid=1 after edge E1, i.e. 2 edges after reset release.
- Redirect sampled at edge Ek: pc=target after Ek, and the target instruction appears at id_* after Ek+1.
- With continuous id_ready=1 and no stall, throughput is one instruction per cycle.
- id_* outputs are registered buffer state and never combinational from inst_i.
- rst asserted mid-operation takes effect at the next edge and discards all buffered and pending state.

## Configuration
- IF_PREFETCH_EN defined: 2-entry buffer.
  - Room is registered count<2, so there is no combinational path from id_ready to ce or pc.
- IF_PREFETCH_EN undefined: 1-entry buffer.
  - Room is count==0 || (count==1 && id_ready), a combinational path from id_ready.
  - Throughput is identical; this configuration saves one entry of storage.

## Structure
- `defines.v` holds InstAddrBus, InstBus, ZeroWord, RstEnable, ChipEnable/ChipDisable, and a new constant PcResetAddr=32'h0.
- Sub-module if_buffer: parameter-free FIFO of {pc, inst}.
  - Ports: push, pop, clear, room, head, valid.
  - Depth is selected by IF_PREFETCH_EN.
- inst_fetch contains the PC register, the pending-branch register and the redirect priority logic.

## Test plan
- Reset then run, with ROM words 0x34011100 at address 0 and 0x34020020 at address 4, id_ready=1 → id_pc 0,4,8 on consecutive cycles starting 2 edges after reset; id_inst matches.
- id_ready=0 for 4 cycles → with the macro, count holds at 2 and pc stops at 8. On release, no instruction is lost or duplicated.
- branch_flag_i pulse with target 0x40 while the buffer holds entries → next id_pc=0x40, and no old PCs appear afterwards.
- branch_flag_i during stall_pc=1 with target 0x80, stall held 3 cycles → pc unchanged during the stall, then pc=0x80 on the first unstalled edge.
- flush with new_pc=0x20 in the same cycle as branch_flag_i and stall_pc=1 → pc=0x20, pending branch discarded.
- pc=0xFFFFFFFC, fetch fires → next pc=0x00000000; a redirect target of 0x43 → pc=0x40.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset constants and the fetch-buffer entry type
// for the OpenMIPS instruction-fetch front end.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD     = '0;
    localparam logic [INST_ADDR_W-1:0] PC_RESET_ADDR = 32'h0000_0000;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] align_word(
        input logic [INST_ADDR_W-1:0] addr
    );
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch_buffer.sv
// Fetch buffer of {pc, inst}; two entries when IF_PREFETCH_EN is
// defined (registered room), otherwise one entry (room looks at pop).
import inst_fetch_pkg::*;

module if_buffer (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         room,
    output fetch_entry_t head,
    output logic         valid
);

    logic [1:0]   count;
    fetch_entry_t slot0;

    assign head  = slot0;
    assign valid = (count != 2'd0);

`ifdef IF_PREFETCH_EN
    fetch_entry_t slot1;

    assign room = (count != 2'd2);

    // room is registered, so push&&pop only happens with one entry held
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else if (push && pop) begin
            slot0 <= din;
        end else if (push) begin
            if (count == 2'd0) begin
                slot0 <= din;
            end else begin
                slot1 <= din;
            end
            count <= count + 2'd1;
        end else if (pop) begin
            slot0 <= slot1;
            count <= count - 2'd1;
        end
    end
`else
    assign room = (count == 2'd0) || pop;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            count <= 2'd0;
            slot0 <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else if (push) begin
            slot0 <= din;
            count <= 2'd1;
        end else if (pop) begin
            count <= 2'd0;
        end
    end
`endif

endmodule

// File: rtl/inst_fetch.sv
// PC register, pending-branch register and redirect priority in front
// of the fetch buffer. Buffer depth selected by IF_PREFETCH_EN.
import inst_fetch_pkg::*;

module inst_fetch (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_pc,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   ce,
    input  logic [INST_W-1:0]      inst_i,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst
);

    logic                   pend;
    logic [INST_ADDR_W-1:0] pend_target;
    logic                   br_apply;
    logic [INST_ADDR_W-1:0] br_target;
    logic                   room;
    logic                   push;
    logic                   pop;
    logic                   clear;
    fetch_entry_t           din;
    fetch_entry_t           head;

    // a fresh branch overrides whatever was pending
    assign br_apply  = !stall_pc && (branch_flag_i || pend);
    assign br_target = branch_flag_i
                     ? align_word(branch_target_address_i)
                     : pend_target;

    assign clear = flush || br_apply;
    assign pop   = id_valid && id_ready;
    assign push  = ce && !stall_pc && !clear && room;
    assign din   = '{pc: pc, inst: inst_i};

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc          <= PC_RESET_ADDR;
            ce          <= CHIP_DISABLE;
            pend        <= 1'b0;
            pend_target <= ZERO_WORD;
        end else begin
            ce <= CHIP_ENABLE;
            if (flush) begin
                pc   <= align_word(new_pc);
                pend <= 1'b0;
            end else if (br_apply) begin
                pc   <= br_target;
                pend <= 1'b0;
            end else begin
                if (branch_flag_i) begin
                    pend        <= 1'b1;
                    pend_target <= align_word(branch_target_address_i);
                end
                if (push) begin
                    pc <= pc + 32'd4;
                end
            end
        end
    end

    if_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (din),
        .room  (room),
        .head  (head),
        .valid (id_valid)
    );

    assign id_pc   = head.pc;
    assign id_inst = head.inst;

endmodule
